// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encoding and defaults.
package uart_tx_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_DONE = 2'd2,
        GAP       = 2'd3
    } state_t;

    localparam int SB_TICK_DEFAULT = 16;

    // Width of an index or counter that must hold values 0..n-1 (never zero bits).
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin selector: first asserted request after last_grant.
module rr_pick
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NREQ = 4,
    localparam int IDXW = idx_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDXW-1:0] last_grant,
    output logic            any,
    output logic [IDXW-1:0] idx
);

    function automatic logic [IDXW-1:0] offset_idx(input logic [IDXW-1:0] base, input int k);
        return IDXW'((int'(base) + k) % NREQ);
    endfunction

    always_comb begin
        any = 1'b0;
        idx = '0;
        // Walk from the farthest candidate to the nearest so the nearest one wins.
        for (int k = NREQ; k >= 1; k--) begin
            if (req[offset_idx(last_grant, k)]) begin
                any = 1'b1;
                idx = offset_idx(last_grant, k);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding bytes from NREQ requesters into a single UART transmitter.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int DBITS    = 8,
    parameter int SB_TICK  = SB_TICK_DEFAULT,
    parameter int GAP_BITS = 1,
    localparam int IDXW    = idx_width(NREQ)
) (
    input  logic                  clk_100MHz,
    input  logic                  reset,
    input  logic                  tick,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*DBITS-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    output logic                  tx_start,
    output logic [DBITS-1:0]      tx_data,
    input  logic                  tx_done,
    output logic [IDXW-1:0]       grant_id,
    output logic                  busy
);

    localparam int GAP_TICKS = GAP_BITS * SB_TICK;
    localparam int GCW       = idx_width(GAP_TICKS);
    localparam logic [GCW-1:0] GAP_LAST = GCW'(GAP_TICKS - 1);

    state_t          state, state_next;
    logic            tick_q;
    logic            tick_rise;
    logic [GCW-1:0]  gap_cnt;
    logic [IDXW-1:0] last_grant;
    logic            pick_any;
    logic [IDXW-1:0] pick_idx;
    logic            grant;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req        (req_valid),
        .last_grant (last_grant),
        .any        (pick_any),
        .idx        (pick_idx)
    );

    assign tick_rise = tick & ~tick_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        grant      = 1'b0;
        tx_start   = 1'b0;
        busy       = (state != IDLE);
        req_ready  = '0;
        unique case (state)
            IDLE: begin
                // NOTE: req_ready is combinational, so it is gated by reset to stay low while reset is held.
                if (pick_any && !reset) begin
                    grant      = 1'b1;
                    state_next = START;
                end
            end
            START: begin
                tx_start   = 1'b1;
                state_next = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (tx_done) begin
                    state_next = (GAP_BITS == 0) ? IDLE : GAP;
                end
            end
            GAP: begin
                if (tick_rise && gap_cnt == GAP_LAST) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        if (grant) begin
            req_ready[pick_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            tx_data    <= '0;
            grant_id   <= '0;
            last_grant <= IDXW'(NREQ - 1);
            tick_q     <= 1'b0;
            gap_cnt    <= '0;
        end else begin
            tick_q <= tick;
            if (grant) begin
                tx_data    <= req_data[pick_idx*DBITS +: DBITS];
                grant_id   <= pick_idx;
                last_grant <= pick_idx;
            end
            // Held at zero outside GAP, so every GAP visit starts counting from zero.
            if (state != GAP) begin
                gap_cnt <= '0;
            end else if (tick_rise) begin
                gap_cnt <= gap_cnt + 1'b1;
            end
        end
    end

endmodule
